// File: rtl/pcache_dm.sv
`default_nettype none
// ============================================================================
// Module   : pcache_dm
// Brief    : Direct-mapped write-through, no-write-allocate cache with burst
//            line refill, flush request and saturating hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module pcache_dm #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int INDEX_BITS = 4,
    parameter int LINE_WORDS = 4,
    parameter int COUNT_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               PStrobe,
    input  logic               PRw,
    input  logic [ADDR_W-1:0]  PAddress,
    input  logic [DATA_W-1:0]  PData_out,
    output logic [DATA_W-1:0]  PData_in,
    output logic               CReady,
    input  logic               Flush,
    output logic               SysStrobe,
    output logic               SysRW,
    output logic [ADDR_W-1:0]  SysAddress,
    output logic [DATA_W-1:0]  SysData_in,
    input  logic [DATA_W-1:0]  SysData_out,
    input  logic               SysReady,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count
);

    localparam int c_OFF   = $clog2(LINE_WORDS);
    localparam int c_OFF_W = (c_OFF > 0) ? c_OFF : 1;
    localparam int c_LINES = 1 << INDEX_BITS;
    localparam int c_WA_W  = ADDR_W - 2;
    localparam int c_TAG_W = c_WA_W - c_OFF - INDEX_BITS;
    localparam logic [c_WA_W-1:0]  c_OFF_MASK = c_WA_W'(LINE_WORDS - 1);
    localparam logic [c_OFF_W-1:0] c_LAST_BEAT = c_OFF_W'(LINE_WORDS - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_REFILL = 2'd1;
    localparam logic [1:0] c_WRITE  = 2'd2;
    localparam logic [1:0] c_WDONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_LINES-1:0] r_valid;
    logic [c_TAG_W-1:0] r_tag  [c_LINES];
    logic [DATA_W-1:0]  r_data [c_LINES][LINE_WORDS];
    logic               r_flush_pending;
    logic               r_replay;
    logic [c_WA_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic [c_OFF_W-1:0] r_beat;
    logic [COUNT_W-1:0] r_hit_cnt;
    logic [COUNT_W-1:0] r_miss_cnt;

    // Processor-side decode of the incoming word address
    logic [c_WA_W-1:0]     w_p_waddr;
    logic [INDEX_BITS-1:0] w_p_index;
    logic [c_TAG_W-1:0]    w_p_tag;
    logic [c_OFF_W-1:0]    w_p_offset;
    logic                  w_p_hit;
    logic                  w_unused_addr;

    assign w_p_waddr     = PAddress[ADDR_W-1:2];
    assign w_p_index     = w_p_waddr[c_OFF +: INDEX_BITS];
    assign w_p_tag       = w_p_waddr[c_WA_W-1 -: c_TAG_W];
    assign w_p_offset    = c_OFF_W'(w_p_waddr & c_OFF_MASK);
    assign w_p_hit       = r_valid[w_p_index] && (r_tag[w_p_index] == w_p_tag);
    assign w_unused_addr = ^PAddress[1:0];

    // Decode of the latched address used by REFILL and WRITE
    logic [INDEX_BITS-1:0] w_r_index;
    logic [c_TAG_W-1:0]    w_r_tag;
    logic [c_OFF_W-1:0]    w_r_offset;
    logic                  w_r_hit;

    assign w_r_index  = r_waddr[c_OFF +: INDEX_BITS];
    assign w_r_tag    = r_waddr[c_WA_W-1 -: c_TAG_W];
    assign w_r_offset = c_OFF_W'(r_waddr & c_OFF_MASK);
    assign w_r_hit    = r_valid[w_r_index] && (r_tag[w_r_index] == w_r_tag);

    logic w_idle, w_do_flush, w_req, w_rd_hit, w_rd_miss, w_wr;
    logic w_beat_ack, w_fill_done, w_wr_ack;

    assign w_idle      = (r_state == c_IDLE);
    assign w_do_flush  = w_idle && r_flush_pending;
    assign w_req       = w_idle && !r_flush_pending && PStrobe;
    assign w_rd_hit    = w_req && PRw && w_p_hit;
    assign w_rd_miss   = w_req && PRw && !w_p_hit;
    assign w_wr        = w_req && !PRw;
    assign w_beat_ack  = (r_state == c_REFILL) && SysReady;
    assign w_fill_done = w_beat_ack && (r_beat == c_LAST_BEAT);
    assign w_wr_ack    = (r_state == c_WRITE) && SysReady;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_rd_miss) begin
                    w_next_state = c_REFILL;
                end else if (w_wr) begin
                    w_next_state = c_WRITE;
                end
            end
            c_REFILL: if (w_fill_done) w_next_state = c_IDLE;
            c_WRITE:  if (SysReady)    w_next_state = c_WDONE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        CReady     = 1'b0;
        PData_in   = '0;
        SysStrobe  = 1'b0;
        SysRW      = 1'b1;
        SysAddress = '0;
        SysData_in = '0;
        if (!reset) begin
            case (r_state)
                c_IDLE: begin
                    if (!r_flush_pending) begin
                        if (!PStrobe) begin
                            CReady = 1'b1;
                        end else if (PRw && w_p_hit) begin
                            CReady   = 1'b1;
                            PData_in = r_data[w_p_index][w_p_offset];
                        end
                    end
                end
                c_REFILL: begin
                    SysStrobe  = 1'b1;
                    SysAddress = {r_waddr | c_WA_W'(r_beat), 2'b00};
                end
                c_WRITE: begin
                    SysStrobe  = 1'b1;
                    SysRW      = 1'b0;
                    SysAddress = {r_waddr, 2'b00};
                    SysData_in = r_wdata;
                end
                default: CReady = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid         <= '0;
            r_flush_pending <= 1'b0;
            r_replay        <= 1'b0;
            r_waddr         <= '0;
            r_wdata         <= '0;
            r_beat          <= '0;
            r_hit_cnt       <= '0;
            r_miss_cnt      <= '0;
        end else begin
            r_flush_pending <= Flush || (r_flush_pending && !w_do_flush);
            // The first IDLE cycle after a refill replays the held request
            r_replay        <= w_fill_done;
            if (w_do_flush) begin
                r_valid <= '0;
            end
            if (w_rd_hit && !r_replay && (r_hit_cnt != {COUNT_W{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_rd_miss) begin
                r_valid[w_p_index] <= 1'b0;
                r_waddr            <= w_p_waddr & ~c_OFF_MASK;
                r_beat             <= '0;
                if (r_miss_cnt != {COUNT_W{1'b1}}) begin
                    r_miss_cnt <= r_miss_cnt + 1'b1;
                end
            end
            if (w_wr) begin
                r_waddr <= w_p_waddr;
                r_wdata <= PData_out;
            end
            if (w_beat_ack) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_fill_done) begin
                r_valid[w_r_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_beat_ack) begin
            r_data[w_r_index][r_beat] <= SysData_out;
        end
        if (w_fill_done) begin
            r_tag[w_r_index] <= w_r_tag;
        end
        if (w_wr_ack && w_r_hit) begin
            r_data[w_r_index][w_r_offset] <= r_wdata;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pcache_dm.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcache_dm
// Brief    : Self-checking bench for pcache_dm with a memory responder and a
//            line-presence reference model of the cache.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcache_dm;

    localparam int c_MAX_WAIT = 400;

    logic        clock = 1'b0;
    logic        reset;
    logic        PStrobe, PRw, Flush;
    logic [31:0] PAddress, PData_out, PData_in;
    logic        CReady;
    logic        SysStrobe, SysRW, SysReady;
    logic [31:0] SysAddress, SysData_in, SysData_out;
    logic [15:0] hit_count, miss_count;
    logic [3:0]  c4_hit_count, c4_miss_count;
    logic [31:0] unused_c4_pdata, unused_c4_addr, unused_c4_wdata;
    logic        unused_c4_cready, unused_c4_strobe, unused_c4_rw;

    always #5 clock = ~clock;

    pcache_dm #(.ADDR_W(32), .DATA_W(32), .INDEX_BITS(4), .LINE_WORDS(4), .COUNT_W(16)) u_dut (
        .clock(clock), .reset(reset), .PStrobe(PStrobe), .PRw(PRw), .PAddress(PAddress),
        .PData_out(PData_out), .PData_in(PData_in), .CReady(CReady), .Flush(Flush),
        .SysStrobe(SysStrobe), .SysRW(SysRW), .SysAddress(SysAddress), .SysData_in(SysData_in),
        .SysData_out(SysData_out), .SysReady(SysReady), .hit_count(hit_count), .miss_count(miss_count)
    );

    // Narrow-counter instance sees identical stimulus; only its counters are checked
    pcache_dm #(.ADDR_W(32), .DATA_W(32), .INDEX_BITS(4), .LINE_WORDS(4), .COUNT_W(4)) u_dut_c4 (
        .clock(clock), .reset(reset), .PStrobe(PStrobe), .PRw(PRw), .PAddress(PAddress),
        .PData_out(PData_out), .PData_in(unused_c4_pdata), .CReady(unused_c4_cready), .Flush(Flush),
        .SysStrobe(unused_c4_strobe), .SysRW(unused_c4_rw), .SysAddress(unused_c4_addr),
        .SysData_in(unused_c4_wdata), .SysData_out(SysData_out), .SysReady(SysReady),
        .hit_count(c4_hit_count), .miss_count(c4_miss_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_miss = 0;
    int mem_delay = 0;
    int resp_wait = 0;

    logic [31:0] sys_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] log_addr [$];
    logic        log_rw   [$];
    logic [31:0] log_data [$];
    bit          m_valid  [16];
    int unsigned m_line   [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] sys_rd(input logic [31:0] a);
        return sys_mem.exists(a) ? sys_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [63:0] sat(input int cnt, input int w);
        longint lim = (longint'(1) << w) - 1;
        return (longint'(cnt) > lim) ? 64'(lim) : 64'(cnt);
    endfunction

    // 16-byte lines, 16 lines: a line is present when its slot holds its line number
    function automatic bit m_hit(input logic [31:0] a);
        int unsigned ln = a >> 4;
        return m_valid[ln % 16] && (m_line[ln % 16] == ln);
    endfunction

    function automatic void m_fill(input logic [31:0] a);
        int unsigned ln = a >> 4;
        m_valid[ln % 16] = 1'b1;
        m_line[ln % 16]  = ln;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void log_clear();
        log_addr.delete();
        log_rw.delete();
        log_data.delete();
    endfunction

    // Memory: acknowledges each strobed beat after mem_delay wait cycles
    always @(negedge clock) begin
        #2;
        if (SysStrobe === 1'b1) begin
            if (resp_wait >= mem_delay) begin
                SysReady  = 1'b1;
                resp_wait = 0;
                if (SysRW) SysData_out = sys_rd(SysAddress);
                else sys_mem[SysAddress] = SysData_in;
                log_addr.push_back(SysAddress);
                log_rw.push_back(SysRW);
                log_data.push_back(SysRW ? SysData_out : SysData_in);
            end else begin
                SysReady = 1'b0;
                resp_wait++;
            end
        end else begin
            SysReady  = 1'b0;
            resp_wait = 0;
        end
    end

    task automatic do_read(input logic [31:0] addr, input int flush_at,
                           output int low, output logic [31:0] data);
        @(negedge clock);
        PStrobe = 1'b1; PRw = 1'b1; PAddress = addr;
        low = 0; data = '0;
        Flush = (flush_at == 0);
        forever begin
            #1;
            if (CReady === 1'b1) begin
                data = PData_in;
                break;
            end
            if (low >= c_MAX_WAIT) begin
                check("read_timeout", 64'(low), 64'(c_MAX_WAIT - 1));
                break;
            end
            low++;
            @(negedge clock);
            Flush = (low == flush_at);
        end
        @(negedge clock);
        PStrobe = 1'b0; Flush = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, output int low);
        @(negedge clock);
        PStrobe = 1'b1; PRw = 1'b0; PAddress = addr; PData_out = data;
        ref_mem[addr] = data;
        low = 0;
        forever begin
            #1;
            if (CReady === 1'b1) break;
            if (low >= c_MAX_WAIT) begin
                check("write_timeout", 64'(low), 64'(c_MAX_WAIT - 1));
                break;
            end
            low++;
            @(negedge clock);
        end
        @(negedge clock);
        PStrobe = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; PStrobe = 1'b0; Flush = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_clear();
        exp_hits = 0;
        exp_miss = 0;
    endtask

    task automatic checked_read(input string tag, input logic [31:0] addr, input int delay);
        int low;
        logic [31:0] data;
        bit hit;
        hit = m_hit(addr);
        do_read(addr, -1, low, data);
        check({tag, "_lat"}, 64'(low), hit ? 64'd0 : 64'(1 + 4 * (delay + 1)));
        check({tag, "_data"}, 64'(data), 64'(ref_rd(addr)));
        if (hit) exp_hits++;
        else begin
            exp_miss++;
            m_fill(addr);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low;
        logic [31:0] data;
        logic [31:0] a;

        reset = 1'b1; PStrobe = 1'b0; PRw = 1'b1; PAddress = '0; PData_out = '0; Flush = 1'b0;
        SysReady = 1'b0; SysData_out = '0;
        m_clear();
        repeat (3) @(negedge clock);
        #1;
        check("rst_creday", 64'(CReady), 64'd0);
        check("rst_sysstrobe", 64'(SysStrobe), 64'd0);
        check("rst_sysrw", 64'(SysRW), 64'd1);
        check("rst_sysaddr", 64'(SysAddress), 64'd0);
        check("rst_hits", 64'(hit_count), 64'd0);
        check("rst_miss", 64'(miss_count), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 check("idle_creday", 64'(CReady), 64'd1);

        // Refill of line 0x100 then a same-line hit
        mem_delay = 0; log_clear();
        do_read(32'h100, -1, low, data);
        check("t1_miss_lat", 64'(low), 64'd5);
        check("t1_miss_data", 64'(data), 64'hA0);
        check("t1_beats", 64'(log_addr.size()), 64'd4);
        for (int i = 0; i < log_addr.size() && i < 4; i++) begin
            check("t1_beat_addr", 64'(log_addr[i]), 64'(32'h100 + 4 * i));
            check("t1_beat_rw", 64'(log_rw[i]), 64'd1);
        end
        m_fill(32'h100); exp_miss++;
        check("t1_miss_cnt", 64'(miss_count), 64'(exp_miss));
        check("t1_hit_cnt0", 64'(hit_count), 64'd0);
        checked_read("t1_hit", 32'h108, 0);
        check("t1_hit_cnt1", 64'(hit_count), 64'(exp_hits));

        // Write-through with slow memory, then no-allocate write
        mem_delay = 3; log_clear();
        do_write(32'h104, 32'h55, low);
        check("t2_wr_lat", 64'(low), 64'd5);
        check("t2_wr_beats", 64'(log_addr.size()), 64'd1);
        if (log_addr.size() > 0) begin
            check("t2_wr_addr", 64'(log_addr[0]), 64'h104);
            check("t2_wr_rw", 64'(log_rw[0]), 64'd0);
            check("t2_wr_data", 64'(log_data[0]), 64'h55);
        end
        #1 check("t2_post_strobe", 64'(SysStrobe), 64'd0);
        mem_delay = 0;
        checked_read("t2_rd104", 32'h104, 0);
        do_write(32'h400, 32'h77, low);
        check("t2_wr400_lat", 64'(low), 64'd2);
        checked_read("t2_rd400", 32'h400, 0);
        check("t2_miss_cnt", 64'(miss_count), 64'(exp_miss));

        // Conflict misses on index 0
        apply_reset();
        checked_read("t3_a", 32'h100, 0);
        checked_read("t3_b", 32'h500, 0);
        checked_read("t3_c", 32'h100, 0);
        check("t3_miss_cnt", 64'(miss_count), 64'd3);
        check("t3_hit_cnt", 64'(hit_count), 64'd0);

        // Flush during refill beat 2: refill finishes, flush, request misses again
        checked_read("t4_pre", 32'h110, 0);
        do_read(32'h600, 3, low, data);
        check("t4_flush_lat", 64'(low), 64'd11);
        check("t4_flush_data", 64'(data), 64'(ref_rd(32'h600)));
        exp_miss += 2;
        m_clear(); m_fill(32'h600);
        check("t4_miss_cnt", 64'(miss_count), 64'(exp_miss));
        checked_read("t4_rd110", 32'h110, 0);
        checked_read("t4_rd600", 32'h600, 0);

        // Reset in the middle of a refill
        mem_delay = 0;
        @(negedge clock);
        PStrobe = 1'b1; PRw = 1'b1; PAddress = 32'h700;
        repeat (3) @(negedge clock);
        reset = 1'b1; PStrobe = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t5_strobe", 64'(SysStrobe), 64'd0);
        check("t5_hits", 64'(hit_count), 64'd0);
        check("t5_miss", 64'(miss_count), 64'd0);
        m_clear(); exp_hits = 0; exp_miss = 0;
        log_clear();
        checked_read("t5_rd100", 32'h100, 0);
        check("t5_beats", 64'(log_addr.size()), 64'd4);

        // Counter saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) begin
            do_read(32'h10C, -1, low, data);
            exp_hits++;
        end
        check("t6_hit16", 64'(hit_count), 64'(exp_hits));
        check("t6_hit4", 64'(c4_hit_count), sat(exp_hits, 4));
        check("t6_miss4", 64'(c4_miss_count), sat(exp_miss, 4));

        // Randomized mix of reads and writes
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: a = 32'h000;
                1: a = 32'h100;
                2: a = 32'h500;
                3: a = 32'h040;
                4: a = 32'h1C0;
                default: a = 32'h900;
            endcase
            a = a + 32'($urandom_range(0, 3) * 4);
            mem_delay = $urandom_range(0, 2);
            if ($urandom_range(0, 9) < 7) begin
                checked_read("rnd_rd", a, mem_delay);
            end else begin
                do_write(a, $urandom, low);
                check("rnd_wr_lat", 64'(low), 64'(mem_delay + 2));
            end
        end
        check("end_hit16", 64'(hit_count), sat(exp_hits, 16));
        check("end_miss16", 64'(miss_count), sat(exp_miss, 16));
        check("end_hit4", 64'(c4_hit_count), sat(exp_hits, 4));
        check("end_miss4", 64'(c4_miss_count), sat(exp_miss, 4));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
